// File: rtl/wordcount_pkg.sv
// Shared types and constants for the wordcount command sequencer:
// legal command codes, the queued descriptor layout and the issue FSM states.
package wordcount_pkg;

    localparam logic [31:0] CMD_SEARCH_AND_ADD = 32'd1;
    localparam logic [31:0] CMD_RESULT_COPY    = 32'd2;
    localparam logic [31:0] CMD_ACCUM_CLEAR    = 32'd3;

    typedef struct packed {
        logic [31:0] command;
        logic [31:0] num_of_words;
        logic [63:0] memory_offset;
    } cmd_desc_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_KICK      = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4
    } seq_state_t;

    function automatic logic is_legal_cmd(input logic [31:0] code);
        return (code == CMD_SEARCH_AND_ADD) || (code == CMD_RESULT_COPY) ||
               (code == CMD_ACCUM_CLEAR);
    endfunction

endpackage

// File: rtl/wordcount_cmd_fifo.sv
// Descriptor FIFO: power-of-two depth, flush empties it and wins over a push,
// head is read straight from the storage registers at the read pointer.
module wordcount_cmd_fifo
    import wordcount_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush_i,
    input  logic      push_i,
    input  cmd_desc_t push_data_i,
    input  logic      pop_i,
    output cmd_desc_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    cmd_desc_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push_s, do_pop_s;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Next pointer/occupancy state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        do_push_s = 1'b0;
        do_pop_s  = 1'b0;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            do_push_s = push_i && !full_o;
            do_pop_s  = pop_i && !empty_o;
            wr_ptr_d  = do_push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
            rd_ptr_d  = do_pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer, occupancy and storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/wordcount_cmd_sequencer.sv
// Queues host command descriptors and issues them one at a time to the
// wordcount top as single-cycle kicks, tracking completions, drops and lost kicks.
module wordcount_cmd_sequencer
    import wordcount_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_cmd_valid,
    output logic        s_cmd_ready,
    input  logic [31:0] s_cmd_command,
    input  logic [31:0] s_cmd_num_of_words,
    input  logic [63:0] s_cmd_memory_offset,
    input  logic        flush,
    output logic        kick,
    output logic [31:0] command,
    output logic [31:0] num_of_words,
    output logic [63:0] global_memory_offset,
    input  logic        busy,
    output logic        seq_idle,
    output logic        done,
    output logic [31:0] done_count,
    output logic [15:0] drop_count,
    output logic        ack_timeout_err
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(ACK_TIMEOUT);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    seq_state_t  state_q, state_d;
    cmd_desc_t   desc_q, desc_d;
    cmd_desc_t   head_s, push_data_s;
    logic [TW-1:0] tmo_q, tmo_d;
    logic        kick_q, kick_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] done_cnt_q, done_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        ready_en_q;
    logic        push_s, pop_s, full_s, empty_s;

    // Ready is the pre-pop "not full": a push into a full FIFO is refused even
    // when the sequencer pops in the same cycle (no look-ahead).
    assign s_cmd_ready = ready_en_q && !full_s;
    assign push_s      = s_cmd_valid && s_cmd_ready;
    assign push_data_s = '{command: s_cmd_command, num_of_words: s_cmd_num_of_words,
                           memory_offset: s_cmd_memory_offset};

    wordcount_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .flush_i     (flush),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .full_o      (full_s),
        .empty_o     (empty_s)
    );

    // Issue FSM next state; a flush in IDLE suppresses the pop so nothing queued escapes it.
    always_comb begin
        state_d    = state_q;
        desc_d     = desc_q;
        tmo_d      = tmo_q;
        kick_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        done_cnt_d = done_cnt_q;
        drop_cnt_d = drop_cnt_q;
        pop_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s && !flush) begin
                    pop_s   = 1'b1;
                    desc_d  = head_s;
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (!is_legal_cmd(desc_q.command)) begin
                    drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : (drop_cnt_q + 16'd1);
                    state_d    = ST_IDLE;
                end else if (!busy) begin
                    kick_d  = 1'b1;
                    state_d = ST_KICK;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_KICK: begin
                tmo_d   = TMO_LOAD;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_q <= TMO_ONE) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q - TMO_ONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!busy) begin
                    done_d     = 1'b1;
                    done_cnt_d = done_cnt_q + 32'd1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, held command parameters, pulses and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            desc_q     <= '0;
            tmo_q      <= '0;
            kick_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            done_cnt_q <= 32'd0;
            drop_cnt_q <= 16'd0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            desc_q     <= desc_d;
            tmo_q      <= tmo_d;
            kick_q     <= kick_d;
            done_q     <= done_d;
            err_q      <= err_d;
            done_cnt_q <= done_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            ready_en_q <= 1'b1;
        end
    end

    assign kick                 = kick_q;
    assign command              = desc_q.command;
    assign num_of_words         = desc_q.num_of_words;
    assign global_memory_offset = desc_q.memory_offset;
    assign done                 = done_q;
    assign done_count           = done_cnt_q;
    assign drop_count           = drop_cnt_q;
    assign ack_timeout_err      = err_q;
    assign seq_idle             = (state_q == ST_IDLE) && empty_s;

endmodule
